// File: rtl/dmem_port_arbiter.sv
// dmem_port_arbiter: shares the data-RAM port between the CPU MEM stage and a debug master,
// with a starvation counter that forces a one-cycle CPU stall.
module dmem_port_arbiter #(
  parameter int MAX_WAIT = 4,
  parameter int WAIT_W = 8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        cpu_rd,
  input  logic        cpu_wr,
  input  logic [31:0] cpu_addr,
  input  logic [31:0] cpu_wdata,
  output logic [31:0] cpu_rdata,
  output logic        cpu_stall,
  input  logic        dbg_req,
  input  logic        dbg_we,
  input  logic [31:0] dbg_addr,
  input  logic [31:0] dbg_wdata,
  output logic        dbg_ack,
  output logic [31:0] dbg_rdata,
  output logic        mem_rd,
  output logic        mem_wr,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic [31:0] mem_rdata
);
  typedef enum logic [1:0] {IDLE, STALL, ACK} state_t;
  state_t state, state_nxt;
  logic [WAIT_W-1:0] wait_cnt, wait_nxt;
  logic cpu_busy, dbg_grant, dbg_win;
  assign cpu_busy = cpu_rd | cpu_wr;
  assign dbg_win = dbg_addr[31:28] == 4'h0;
  assign dbg_grant = (state == IDLE && dbg_req && !cpu_busy) || state == STALL;
  assign cpu_stall = state == STALL;
  assign dbg_ack = state == ACK;
  // A granted debug access blocks the CPU entirely, including its write enable.
  always_comb begin
    mem_rd = dbg_grant ? !dbg_we && dbg_win : cpu_rd;
    mem_wr = dbg_grant ? dbg_we && dbg_win : cpu_wr;
    mem_addr = dbg_grant ? dbg_addr : cpu_addr;
    mem_wdata = dbg_grant ? dbg_wdata : cpu_wdata;
    cpu_rdata = dbg_grant ? '0 : mem_rdata;
  end
  always_comb begin
    state_nxt = state;
    wait_nxt = wait_cnt;
    case (state)
      IDLE:
        if (!dbg_req) wait_nxt = '0;
        else if (!cpu_busy) state_nxt = ACK;
        else if (wait_cnt == WAIT_W'(MAX_WAIT - 1)) state_nxt = STALL;
        else wait_nxt = wait_cnt + WAIT_W'(1);
      STALL: state_nxt = ACK;
      default: begin
        state_nxt = IDLE;
        wait_nxt = '0;
      end
    endcase
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      wait_cnt <= '0;
      dbg_rdata <= '0;
    end else begin
      state <= state_nxt;
      wait_cnt <= wait_nxt;
      if (dbg_grant && !dbg_we) dbg_rdata <= dbg_win ? mem_rdata : '0;
    end
  end
endmodule

// File: tb/tb_dmem_port_arbiter.sv
// tb_dmem_port_arbiter: directed stimulus with a latency-rule reference model checked every cycle.
module tb_dmem_port_arbiter;
  localparam int MAX_WAIT = 4;
  logic clk = 0, rst;
  logic cpu_rd, cpu_wr, cpu_stall, dbg_req, dbg_we, dbg_ack, mem_rd, mem_wr;
  logic [31:0] cpu_addr, cpu_wdata, cpu_rdata, dbg_addr, dbg_wdata, dbg_rdata;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;
  logic [31:0] ram [64];
  logic [31:0] mram [64];
  int errors = 0, checks = 0, acks;
  bit m_ack;
  int m_age;
  logic [31:0] m_rdata;

  dmem_port_arbiter #(.MAX_WAIT(MAX_WAIT), .WAIT_W(8)) dut (
    .clk(clk), .rst(rst), .cpu_rd(cpu_rd), .cpu_wr(cpu_wr), .cpu_addr(cpu_addr),
    .cpu_wdata(cpu_wdata), .cpu_rdata(cpu_rdata), .cpu_stall(cpu_stall), .dbg_req(dbg_req),
    .dbg_we(dbg_we), .dbg_addr(dbg_addr), .dbg_wdata(dbg_wdata), .dbg_ack(dbg_ack),
    .dbg_rdata(dbg_rdata), .mem_rd(mem_rd), .mem_wr(mem_wr), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
  );

  always #5 clk = ~clk;
  assign mem_rdata = ram[mem_addr[7:2]];
  always @(posedge clk) if (mem_wr) ram[mem_addr[7:2]] <= mem_wdata;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  // Reference: a request is served on its first CPU-idle cycle, or forcibly (with a stall)
  // once it has waited MAX_WAIT busy cycles; the cycle after service is the ack.
  always @(negedge clk) begin : model
    logic busy, win, g, st, erd, ewr;
    logic [31:0] ea, ew;
    if (rst) begin
      m_ack = 0;
      m_age = 0;
      m_rdata = '0;
    end
    busy = cpu_rd | cpu_wr;
    win = dbg_addr[31:28] == 4'h0;
    st = !m_ack && dbg_req && m_age == MAX_WAIT;
    g = st || (!m_ack && dbg_req && !busy);
    erd = g ? !dbg_we && win : cpu_rd;
    ewr = g ? dbg_we && win : cpu_wr;
    ea = g ? dbg_addr : cpu_addr;
    ew = g ? dbg_wdata : cpu_wdata;
    chk("mem_rd", mem_rd, erd);
    chk("mem_wr", mem_wr, ewr);
    chk("mem_addr", mem_addr, ea);
    if (ewr) chk("mem_wdata", mem_wdata, ew);
    chk("cpu_rdata", cpu_rdata, g ? 32'h0 : mram[ea[7:2]]);
    chk("cpu_stall", cpu_stall, st);
    chk("dbg_ack", dbg_ack, m_ack);
    chk("dbg_rdata", dbg_rdata, m_rdata);
    if (!rst && g && !dbg_we) m_rdata = win ? mram[ea[7:2]] : 32'h0;
    if (ewr) mram[ea[7:2]] = ew;
    if (!rst) begin
      m_age = (!g && !m_ack && dbg_req) ? m_age + 1 : 0;
      m_ack = g;
    end
  end

  initial begin
    for (int i = 0; i < 64; i++) begin
      ram[i] = i == 0 ? 32'h14 : i == 1 ? 32'h3AF2 : 32'h100 + 32'(i) * 17;
      mram[i] = ram[i];
    end
    rst = 1; cpu_rd = 0; cpu_wr = 0; cpu_addr = 0; cpu_wdata = 0;
    dbg_req = 0; dbg_we = 0; dbg_addr = 0; dbg_wdata = 0;
    cyc(); cyc();
    #1 chk("reset stall", cpu_stall, 0);
    chk("reset ack", dbg_ack, 0);
    chk("reset rdata", dbg_rdata, 0);
    rst = 0;
    cyc();
    dbg_req = 1; dbg_we = 0; dbg_addr = 0;
    #1 chk("idle read grant", mem_rd, 1);
    chk("idle read addr", mem_addr, 0);
    cyc();
    #1 chk("idle read ack", dbg_ack, 1);
    chk("idle read data", dbg_rdata, 32'h14);
    dbg_req = 0;
    cyc();
    #1 chk("ack one pulse", dbg_ack, 0);
    dbg_req = 1; dbg_we = 1; dbg_addr = 32'h8; dbg_wdata = 32'hDEADBEEF;
    #1 chk("dbg write en", mem_wr, 1);
    cyc();
    dbg_req = 0; dbg_we = 0; cpu_rd = 1; cpu_addr = 32'h8;
    #1 chk("dbg write ack", dbg_ack, 1);
    chk("cpu reads dbg write", cpu_rdata, 32'hDEADBEEF);
    cyc();
    cpu_addr = 32'hC; dbg_req = 1; dbg_addr = 32'h4;
    for (int c = 0; c < 6; c++) begin
      #1 chk("starve stall", cpu_stall, 32'(c == 4));
      chk("starve ack", dbg_ack, 32'(c == 5));
      if (c == 5) begin
        chk("starve data", dbg_rdata, 32'h3AF2);
        dbg_req = 0;
      end
      cyc();
    end
    cpu_rd = 0;
    dbg_req = 1; dbg_we = 1; dbg_addr = 32'h40000010; dbg_wdata = 32'hABC;
    #1 chk("window write blocked", mem_wr, 0);
    cyc();
    #1 chk("window write ack", dbg_ack, 1);
    dbg_req = 0; dbg_we = 0;
    cyc();
    chk("window ram untouched", ram[4], 32'h144);
    cpu_rd = 1; dbg_req = 1; dbg_addr = 32'h4; dbg_rdata_clear: begin end
    repeat (4) cyc();
    #1 chk("pre-reset stall", cpu_stall, 1);
    rst = 1;
    #1 chk("rst stall", cpu_stall, 0);
    chk("rst ack", dbg_ack, 0);
    chk("rst rdata", dbg_rdata, 0);
    cyc();
    rst = 0; cpu_rd = 0; acks = 0;
    for (int i = 0; i < 4; i++) begin
      #1 if (dbg_ack) begin
        acks++;
        dbg_req = 0;
      end
      cyc();
    end
    chk("post-reset ack count", acks, 1);
    chk("post-reset data", dbg_rdata, 32'h3AF2);
    cpu_wr = 1; cpu_addr = 32'h10; cpu_wdata = 32'h55; dbg_req = 1; dbg_we = 0; dbg_addr = 32'h10;
    #1 chk("collision cpu wins", mem_wr, 1);
    chk("collision wdata", mem_wdata, 32'h55);
    cyc();
    cpu_wr = 0;
    cyc();
    #1 chk("collision ack", dbg_ack, 1);
    chk("collision data", dbg_rdata, 32'h55);
    dbg_req = 0;
    cyc();
    dbg_req = 1; dbg_addr = 32'h40000000;
    #1 chk("window read blocked", mem_rd, 0);
    cyc();
    #1 chk("window read ack", dbg_ack, 1);
    chk("window read data", dbg_rdata, 0);
    dbg_req = 0;
    cyc();
    dbg_req = 1; dbg_addr = 32'h0; acks = 0;
    for (int i = 0; i < 4; i++) begin
      #1 if (dbg_ack) acks++;
      cyc();
    end
    dbg_req = 0;
    chk("back-to-back acks", acks, 2);
    repeat (2) cyc();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
